// File: rtl/memlog_pkg.sv
// Shared constants for the capture-logger sequencer: default geometry,
// stream word width and the FSM state encoding.
package memlog_pkg;

   localparam int AW_DEF     = 15;
   localparam int DW_DEF     = 16;
   localparam int RD_LAT_DEF = 1;
   localparam int WORD_W_DEF = 2 * DW_DEF;

   localparam int ST_W = 3;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ARM      = 3'd1;
   localparam logic [2:0] ST_CAPTURE  = 3'd2;
   localparam logic [2:0] ST_READY    = 3'd3;
   localparam logic [2:0] ST_RD_ISSUE = 3'd4;
   localparam logic [2:0] ST_RD_ADDR  = 3'd5;
   localparam logic [2:0] ST_RD_WAIT  = 3'd6;
   localparam logic [2:0] ST_RD_OUT   = 3'd7;

endpackage

// File: rtl/memlog_rd_addr_gen.sv
// Readout address generator: a loadable wrapping address counter plus a
// remaining-words counter one bit wider so a full-depth window is exact.
module memlog_rd_addr_gen #(
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [AW-1:0] base_i,
   input  logic [AW:0]   len_i,
   input  logic          step_i,
   output logic [AW-1:0] addr_o,
   output logic          last_o
);

   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   remain_q, remain_d;

   // Load takes priority; a step advances the address (wrapping) and consumes one word.
   always_comb begin
      addr_d   = addr_q;
      remain_d = remain_q;
      if (load_i) begin
         addr_d   = base_i;
         // A length of zero encodes the whole memory (2^AW words).
         remain_d = (len_i == '0) ? {1'b1, {AW{1'b0}}} : len_i;
      end else if (step_i) begin
         addr_d   = addr_q + AW'(1);
         remain_d = remain_q - (AW+1)'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         addr_q   <= '0;
         remain_q <= '0;
      end else begin
         addr_q   <= addr_d;
         remain_q <= remain_d;
      end
   end

   assign addr_o = addr_q;
   assign last_o = (remain_q == (AW+1)'(1));

endmodule

// File: rtl/memlog_seq.sv
// Capture-logger sequencer: arms a capture, waits for the logger to fill,
// then streams a host-selected address window out over valid/ready.
//
// Stream handshake: o_word_valid rises with o_word_data and both hold
// stable until a cycle where i_word_ready is also high; that cycle is the
// transfer, and valid drops on the following cycle.
module memlog_seq
   import memlog_pkg::*;
#(
   parameter int BRAM_ADDR_WIDTH = AW_DEF,
   parameter int BRAM_DATA_WIDTH = DW_DEF,
   parameter int RD_LAT          = RD_LAT_DEF
) (
   input  logic                           clk,
   input  logic                           i_rst,
   input  logic                           i_start_log,
   input  logic                           i_read_req,
   input  logic [BRAM_ADDR_WIDTH-1:0]     i_rd_base,
   input  logic [BRAM_ADDR_WIDTH:0]       i_rd_len,
   output logic                           o_run_log,
   output logic                           o_read_log,
   output logic [BRAM_ADDR_WIDTH-1:0]     o_addr_log_to_mem,
   input  logic                           i_mem_full,
   input  logic [2*BRAM_DATA_WIDTH-1:0]   i_data_log_from_mem,
   output logic [2*BRAM_DATA_WIDTH-1:0]   o_word_data,
   output logic                           o_word_valid,
   input  logic                           i_word_ready,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_err,
   output logic [ST_W-1:0]                o_state
);

   localparam int AW    = BRAM_ADDR_WIDTH;
   localparam int WW    = 2 * BRAM_DATA_WIDTH;
   localparam int LAT_W = 2;

   logic [ST_W-1:0]  state_q, state_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [WW-1:0]    word_data_q, word_data_d;
   logic             word_valid_q, word_valid_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             gen_load;
   logic             gen_step;
   logic             gen_last;
   logic [AW-1:0]    gen_addr;

   // Simultaneous start and read in READY: start wins, so no load then.
   assign gen_load = (state_q == ST_READY) && i_read_req && !i_start_log;
   assign gen_step = (state_q == ST_RD_OUT) && i_word_ready;

   memlog_rd_addr_gen #(
      .AW (AW)
   ) u_addr_gen (
      .clk    (clk),
      .rst_i  (i_rst),
      .load_i (gen_load),
      .base_i (i_rd_base),
      .len_i  (i_rd_len),
      .step_i (gen_step),
      .addr_o (gen_addr),
      .last_o (gen_last)
   );

   // Next-state logic, stream word capture and the done/err pulses.
   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      word_data_d  = word_data_q;
      word_valid_d = word_valid_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            err_d = i_read_req;
            if (i_start_log) state_d = ST_ARM;
         end
         ST_ARM: begin
            err_d   = i_read_req;
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            err_d = i_read_req;
            if (i_mem_full) state_d = ST_READY;
         end
         ST_READY: begin
            if (i_start_log) begin
               state_d = ST_ARM;
               err_d   = i_read_req;
            end else if (i_read_req) begin
               state_d = ST_RD_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            err_d   = i_start_log | i_read_req;
            state_d = ST_RD_ADDR;
         end
         ST_RD_ADDR: begin
            err_d   = i_start_log | i_read_req;
            lat_d   = '0;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            err_d = i_start_log | i_read_req;
            if (lat_q == LAT_W'(RD_LAT - 1)) begin
               word_data_d  = i_data_log_from_mem;
               word_valid_d = 1'b1;
               state_d      = ST_RD_OUT;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         ST_RD_OUT: begin
            err_d = i_start_log | i_read_req;
            if (i_word_ready) begin
               word_valid_d = 1'b0;
               if (gen_last) begin
                  done_d  = 1'b1;
                  state_d = ST_READY;
               end else begin
                  state_d = ST_RD_ADDR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops any pending stream word.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         lat_q        <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_d;
         word_data_q  <= word_data_d;
         word_valid_q <= word_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign o_run_log         = (state_q == ST_ARM);
   assign o_read_log        = (state_q == ST_RD_ISSUE);
   assign o_addr_log_to_mem = gen_addr;
   assign o_word_data       = word_data_q;
   assign o_word_valid      = word_valid_q;
   assign o_busy            = (state_q != ST_IDLE) && (state_q != ST_READY);
   assign o_done            = done_q;
   assign o_err             = err_q;
   assign o_state           = state_q;

endmodule

// File: tb/tb_memlog_seq.sv
// Bench for memlog_seq with a small dual-bank logger model fed by an
// incrementing sample counter, a scoreboard of expected stream words and
// a monitor that checks every transfer and the hold rules.
module tb_memlog_seq;
   import memlog_pkg::*;

   localparam int AW     = 4;
   localparam int DW     = 16;
   localparam int WW     = 2 * DW;
   localparam int DEPTH  = 1 << AW;
   localparam int RD_LAT = 1;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_log = 1'b0;
   logic          read_req = 1'b0;
   logic [AW-1:0] rd_base = '0;
   logic [AW:0]   rd_len = '0;
   logic          ready = 1'b0;

   logic          o_run_log, o_read_log, o_word_valid, o_busy, o_done, o_err;
   logic [AW-1:0] o_addr_log_to_mem;
   logic [WW-1:0] o_word_data;
   logic [2:0]    o_state;
   logic          mem_full;
   logic [WW-1:0] mem_rd_data;

   always #5 clk = ~clk;

   memlog_seq #(
      .BRAM_ADDR_WIDTH (AW),
      .BRAM_DATA_WIDTH (DW),
      .RD_LAT          (RD_LAT)
   ) dut (
      .clk                 (clk),
      .i_rst               (rst),
      .i_start_log         (start_log),
      .i_read_req          (read_req),
      .i_rd_base           (rd_base),
      .i_rd_len            (rd_len),
      .o_run_log           (o_run_log),
      .o_read_log          (o_read_log),
      .o_addr_log_to_mem   (o_addr_log_to_mem),
      .i_mem_full          (mem_full),
      .i_data_log_from_mem (mem_rd_data),
      .o_word_data         (o_word_data),
      .o_word_valid        (o_word_valid),
      .i_word_ready        (ready),
      .o_busy              (o_busy),
      .o_done              (o_done),
      .o_err               (o_err),
      .o_state             (o_state)
   );

   // ---------------- logger model ----------------
   logic [WW-1:0] log_mem [DEPTH];
   logic          cap_q = 1'b0;
   logic [5:0]    scnt_q = '0;
   logic          full_q = 1'b0;
   logic [WW-1:0] rd_q = '0;

   always @(posedge clk) begin
      rd_q <= log_mem[o_addr_log_to_mem];
      if (rst) begin
         cap_q  <= 1'b0;
         full_q <= 1'b0;
         scnt_q <= '0;
      end else if (o_run_log) begin
         cap_q  <= 1'b1;
         full_q <= 1'b0;
         scnt_q <= '0;
      end else if (cap_q) begin
         if (scnt_q[0] == 1'b0) log_mem[scnt_q[4:1]][15:0]  <= 16'(scnt_q);
         else                   log_mem[scnt_q[4:1]][31:16] <= 16'(scnt_q);
         scnt_q <= scnt_q + 6'd1;
         if (scnt_q == 6'd31) begin
            cap_q  <= 1'b0;
            full_q <= 1'b1;
         end
      end
   end
   assign mem_full    = full_q;
   assign mem_rd_data = rd_q;

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [WW-1:0] exp_q[$];
   logic [AW-1:0] exp_addr_q[$];

   int hs_cnt = 0, done_cnt = 0, err_cnt = 0, run_cnt = 0, rdlog_cnt = 0;
   int req_cyc = 0, last_rise = 0;
   bit first_pending = 0, spacing_on = 0;
   logic prev_valid = 1'b0, prev_hs = 1'b0;
   logic [WW-1:0] prev_data = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference: captured word at address a holds samples 2a (low bank) and 2a+1 (high bank).
   function automatic logic [WW-1:0] model_word(input int a);
      logic [15:0] lo, hi;
      lo = 16'(2 * a);
      hi = 16'(2 * a + 1);
      return {hi, lo};
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (o_run_log)  run_cnt++;
         if (o_read_log) rdlog_cnt++;
         if (o_err)      err_cnt++;
         if (o_done) begin
            done_cnt++;
            check("done_queue_empty", 64'(exp_q.size()), 0);
         end
         if (prev_valid && !prev_hs) begin
            check("hold_valid", o_word_valid, 1);
            check("hold_data", o_word_data, prev_data);
         end
         if (o_word_valid && !prev_valid) begin
            if (first_pending) begin
               check("first_latency", 64'(cyc - req_cyc), 4);
               first_pending = 0;
            end else if (spacing_on) begin
               check("word_spacing", 64'(cyc - last_rise), 3);
            end
            last_rise = cyc;
         end
         if (o_word_valid && ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got %0h expected no word", o_word_data);
            end else begin
               check("word_data", o_word_data, exp_q.pop_front());
               check("word_addr", o_addr_log_to_mem, exp_addr_q.pop_front());
            end
         end
         prev_valid = o_word_valid;
         prev_hs    = o_word_valid && ready;
         prev_data  = o_word_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int r0);
      for (int i = 0; i < 200; i++) begin
         if (o_state == ST_READY) break;
         tick();
      end
      tick();
      check("capture_state", o_state, ST_READY);
      check("capture_busy", o_busy, 0);
      check("capture_full", mem_full, 1);
      check("run_pulses", 64'(run_cnt - r0), 1);
   endtask

   task automatic capture(input bit inject_read);
      int r0, e0, l0;
      r0 = run_cnt;
      tick(); start_log = 1'b1;
      tick(); start_log = 1'b0;
      check("arm_run", o_run_log, 1);
      check("arm_busy", o_busy, 1);
      tick();
      if (inject_read) begin
         e0 = err_cnt;
         l0 = rdlog_cnt;
         read_req = 1'b1;
         tick(); read_req = 1'b0;
         tick();
         check("capture_read_err", 64'(err_cnt - e0), 1);
         check("capture_read_no_rdlog", 64'(rdlog_cnt - l0), 0);
         check("capture_read_state", o_state, ST_CAPTURE);
      end
      wait_ready(r0);
   endtask

   task automatic issue_read(input int base, input int len);
      int n;
      n = (len == 0) ? DEPTH : len;
      for (int i = 0; i < n; i++) begin
         exp_addr_q.push_back(AW'((base + i) % DEPTH));
         exp_q.push_back(model_word((base + i) % DEPTH));
      end
      tick();
      read_req = 1'b1;
      rd_base  = AW'(base);
      rd_len   = (AW+1)'(len);
      req_cyc  = cyc;
      first_pending = 1;
      tick();
      read_req = 1'b0;
   endtask

   // mode 0: ready held high, 1: ready toggling, 2: random ready
   task automatic run_readout(input int base, input int len, input int mode);
      int h0, d0, n;
      h0 = hs_cnt;
      d0 = done_cnt;
      n  = (len == 0) ? DEPTH : len;
      spacing_on = (mode == 0);
      ready = 1'b1;
      issue_read(base, len);
      for (int i = 0; i < 800; i++) begin
         if (done_cnt != d0) break;
         tick();
         case (mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = ($urandom_range(0, 3) != 0);
         endcase
      end
      tick(); tick(); tick();
      check("done_once", 64'(done_cnt - d0), 1);
      check("handshakes", 64'(hs_cnt - h0), 64'(n));
      check("queue_drained", 64'(exp_q.size()), 0);
      check("readout_state", o_state, ST_READY);
      exp_q.delete();
      exp_addr_q.delete();
      spacing_on = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_run"}, o_run_log, 0);
      check({tag, "_read"}, o_read_log, 0);
      check({tag, "_addr"}, o_addr_log_to_mem, 0);
      check({tag, "_data"}, o_word_data, 0);
      check({tag, "_valid"}, o_word_valid, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_done"}, o_done, 0);
      check({tag, "_err"}, o_err, 0);
      check({tag, "_state"}, o_state, ST_IDLE);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int e0, l0, r0, h0;
      rst = 1'b1;
      tick(); tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // read request in IDLE is rejected
      e0 = err_cnt;
      l0 = rdlog_cnt;
      read_req = 1'b1;
      tick(); read_req = 1'b0;
      tick(); tick();
      check("idle_read_err", 64'(err_cnt - e0), 1);
      check("idle_read_no_rdlog", 64'(rdlog_cnt - l0), 0);
      check("idle_read_state", o_state, ST_IDLE);

      // capture, with a rejected read request while capturing
      capture(1'b1);

      // full readout, ready high
      run_readout(0, 16, 0);
      // wrap with back-pressure
      run_readout(14, 4, 1);
      // len=0 means the whole memory
      run_readout(5, 0, 0);

      // start and read together in READY: start wins, err pulses
      e0 = err_cnt;
      l0 = rdlog_cnt;
      r0 = run_cnt;
      start_log = 1'b1;
      read_req  = 1'b1;
      tick();
      start_log = 1'b0;
      read_req  = 1'b0;
      check("both_cmd_state", o_state, ST_ARM);
      tick();
      check("both_cmd_err", 64'(err_cnt - e0), 1);
      check("both_cmd_no_rdlog", 64'(rdlog_cnt - l0), 0);
      wait_ready(r0);

      // randomized windows and ready patterns
      for (int k = 0; k < 5; k++) begin
         run_readout(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)), 2);
      end

      // repeat readout without a new capture
      run_readout(3, 7, 1);

      // reset while the second word is presented
      spacing_on = 0;
      h0 = hs_cnt;
      ready = 1'b1;
      issue_read(0, 16);
      for (int i = 0; i < 50; i++) begin
         if (hs_cnt != h0) break;
         tick();
      end
      ready = 1'b0;
      check("reset_first_hs", 64'(hs_cnt - h0), 1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_word_valid) break;
      end
      #1;
      check("reset_second_valid", o_word_valid, 1);
      rst = 1'b1;
      tick();
      check_all_zero("midreset");
      exp_q.delete();
      exp_addr_q.delete();
      first_pending = 0;
      tick();
      rst = 1'b0;
      tick();

      capture(1'b0);
      run_readout(0, 16, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/memlog_seq.md
Name: memlog_seq

Overview:
- Sequencer for the dual-BRAM capture logger: arms a capture, waits for memory-full, then walks a host-selected address window and streams each 32-bit word out over a valid/ready interface.
- Sits between the host command decoder (UART/register side) and the logger.
- The logger owns its storage; this block only drives its run/read/address inputs.

Parameters:
- BRAM_ADDR_WIDTH, 15, logger address width (depth 2^AW words).
- BRAM_DATA_WIDTH, 16, per-bank sample width; stream word is 2*DW.
- RD_LAT, 1, logger read latency in cycles (address to data); legal range 1..3.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_start_log  in  1  one-cycle pulse: begin new capture.
- i_read_req  in  1  one-cycle pulse: begin readout.
- i_rd_base  in  AW  first address to read; sampled with i_read_req.
- i_rd_len  in  AW+1  number of words to read; 0 means 2^AW; sampled with i_read_req.
- o_run_log  out  1  to logger run input.
- o_read_log  out  1  to logger read input.
- o_addr_log_to_mem  out  AW  to logger address input.
- i_mem_full  in  1  from logger full flag.
- i_data_log_from_mem  in  2*DW  from logger read data.
- o_word_data  out  2*DW  stream data.
- o_word_valid  out  1  stream valid.
- i_word_ready  in  1  stream ready.
- o_busy  out  1  high in every state except IDLE and READY.
- o_done  out  1  one-cycle pulse after the last word's handshake.
- o_err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-readout drops the stream word without a handshake.
- States: IDLE, ARM, CAPTURE, READY, RD_ISSUE, RD_ADDR, RD_WAIT, RD_OUT.
- IDLE: i_start_log goes to ARM. i_read_req pulses o_err and the state is unchanged.
- ARM: o_run_log=1 for exactly one cycle, then CAPTURE.
- CAPTURE: waits for i_mem_full=1, then READY.
  - i_start_log and i_read_req are ignored here; i_read_req also pulses o_err.
- READY: i_start_log goes to ARM; the logger restarts from READ or FULL.
  - i_read_req latches base into the address counter and len into the remaining counter, then RD_ISSUE.
  - If both commands arrive in the same cycle, i_start_log wins and o_err pulses.
- RD_ISSUE: o_read_log=1 for one cycle; o_addr_log_to_mem=base. Then RD_ADDR.
- RD_ADDR: present the address for one cycle, then RD_WAIT.
- RD_WAIT: count RD_LAT cycles. On the final count, register i_data_log_from_mem into o_word_data, set o_word_valid=1, go to RD_OUT.
- RD_OUT: hold o_word_data and o_word_valid stable until i_word_ready=1. On the handshake cycle:
  - drop o_word_valid;
  - increment the address modulo 2^AW (wraps AW'1s to 0);
  - decrement the remaining counter.
  - If remaining becomes 0: pulse o_done, go to READY. Otherwise go to RD_ADDR.
- Commands arriving in RD_* states are ignored; o_err pulses for each.
- Latency with RD_LAT=1:
  - i_read_req sampled at cycle 0 gives first o_word_valid at cycle 4.
  - With ready held high, one word every 3 cycles (RD_LAT+2).
- o_addr_log_to_mem holds its last value outside RD_* states.
- The remaining counter is AW+1 bits so len=2^AW is exact.
- A readout can be repeated from READY without a new capture; the data are unchanged.

Decomposition:
- Package memlog_pkg: state encoding localparams, AW/DW defaults, stream word width (2*DW).
- One sub-module, memlog_rd_addr_gen: loadable AW-bit wrapping address counter plus (AW+1)-bit remaining counter with a last flag. The FSM stays in memlog_seq.

Test Plan (AW=4, DW=16, RD_LAT=1, real logger instance, sample input = incrementing counter):
1. Capture: pulse i_start_log → o_run_log high for exactly 1 cycle; i_mem_full rises after 32 sample cycles; state READY; o_busy falls.
2. Readout: i_read_req with base=0, len=16, ready=1 → first valid 4 cycles after req; 16 words at 3-cycle spacing, word k = {2k+1, 2k}; o_done pulses once.
3. Wrap and back-pressure: base=14, len=4, ready toggling 1/0 → addresses 14,15,0,1; data held stable while ready=0; exactly 4 handshakes.
4. len=0: base=5 → 16 words, addresses 5..15 then 0..4; o_done after the 16th handshake.
5. Illegal commands:
   - i_read_req in IDLE or CAPTURE → o_err one cycle, no o_read_log.
   - i_start_log and i_read_req in the same READY cycle → ARM plus o_err.
6. Reset at the second o_word_valid of a readout → next cycle all outputs 0, state IDLE; a fresh capture then readout behaves as scenario 2.
